fp_add_sub_issue: RTL



---
 rtl/fp_add_sub_issue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fp_add_sub_issue.sv
// Operand FIFO feeding an external combinational FP add/sub core, plus a
// registered result slot carrying IEEE-754 classification flags.
module fp_add_sub_issue #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_op,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_op,
  input  logic [WIDTH-1:0]         add_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [3:0]       out_flags_q, out_flags_d;

  logic   push, pop, slot_free, not_empty;
  entry_t head;

  logic [EXP_BITS-1:0]  res_e;
  logic [MANT_BITS-1:0] res_m;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q < DEPTH_C) && !rst;
  assign slot_free = !out_valid_q || out_ready;
  assign push      = in_valid && in_ready;
  // Pop uses pre-edge occupancy, so a fresh push into an empty FIFO waits a cycle.
  assign pop       = not_empty && slot_free;

  assign head   = not_empty ? mem_q[rd_ptr_q] : '0;
  assign add_a  = head.a;
  assign add_b  = head.b;
  assign add_op = head.op;

  assign res_e = add_result[WIDTH-2 -: EXP_BITS];
  assign res_m = add_result[MANT_BITS-1:0];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, op: in_op};
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      out_valid_d  = 1'b1;
      out_result_d = add_result;
      // {nan, inf, zero, sign}; denormals only ever report sign.
      out_flags_d  = {(&res_e) && (|res_m),
                      (&res_e) && !(|res_m),
                      !(|res_e) && !(|res_m),
                      add_result[WIDTH-1]};
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign count      = count_q;

endmodule
